plru_replacement_unit: RTL and testbench

- Per-set tree-PLRU state store and victim selector for set-associative caches.
- Holds NUM_WAYS-1 PLRU bits for each of NUM_SETS cache indices.
- Updates the bits on hit or fill, and returns a registered victim way for a lookup.
- Supports a multi-cycle flush sweep; sits between the cache controller FSM and the tag/valid array.

---
 rtl/plru_replacement_unit.sv | 134 +++++++++++++
 tb/tb_plru_replacement_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_replacement_unit.sv
// Per-set tree-PLRU state store with registered victim selection and a
// one-set-per-cycle flush sweep.
module plru_replacement_unit #(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned LOG_WAYS = 2,
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned LOG_SETS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LOG_SETS-1:0] req_index,
    input  logic [NUM_WAYS-1:0] req_way_valids,
    input  logic                upd_valid,
    input  logic [LOG_SETS-1:0] upd_index,
    input  logic [LOG_WAYS-1:0] upd_way,
    input  logic                flush_req,
    output logic                busy,
    output logic                victim_valid,
    output logic [LOG_WAYS-1:0] victim_way,
    output logic                victim_was_free
);

    localparam int unsigned NODES = NUM_WAYS - 1;
    localparam int unsigned CNT_W = LOG_SETS + 1;

    // Point every node on the path to 'way' away from it.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits,
                                               input logic [LOG_WAYS-1:0] way);
        logic [NODES-1:0] nb;
        int unsigned      node;
        logic             dir;
        nb   = bits;
        node = 0;
        for (int l = 0; l < int'(LOG_WAYS); l++) begin
            dir      = way[LOG_WAYS-1-l];
            nb[node] = ~dir;
            node     = 2 * node + 1 + 32'(dir);
        end
        return nb;
    endfunction

    // Follow the node bits from the root down to a leaf.
    function automatic logic [LOG_WAYS-1:0] walk(input logic [NODES-1:0] bits);
        logic [LOG_WAYS-1:0] way;
        int unsigned         node;
        logic                dir;
        way  = '0;
        node = 0;
        for (int l = 0; l < int'(LOG_WAYS); l++) begin
            dir                 = bits[node];
            way[LOG_WAYS-1-l]   = dir;
            node                = 2 * node + 1 + 32'(dir);
        end
        return way;
    endfunction

    logic [NODES-1:0]    plru_q [NUM_SETS];
    logic [CNT_W-1:0]    sweep_cnt_q;
    logic                busy_q;
    logic                req_ready_q;
    logic                victim_valid_q;
    logic [LOG_WAYS-1:0] victim_way_q;
    logic                victim_free_q;

    logic                req_fire_c;
    logic                upd_fire_c;
    logic [NODES-1:0]    upd_bits_c;
    logic [NODES-1:0]    req_bits_c;
    logic [LOG_WAYS-1:0] sel_way_c;
    logic                sel_free_c;

    // Accept logic, update bits and victim selection (with same-set forwarding).
    always_comb begin
        req_fire_c = req_valid && !busy_q;
        upd_fire_c = upd_valid && !busy_q;
        upd_bits_c = touch(plru_q[upd_index], upd_way);
        req_bits_c = (upd_fire_c && (upd_index == req_index)) ? upd_bits_c
                                                              : plru_q[req_index];
        sel_way_c  = walk(req_bits_c);
        sel_free_c = 1'b0;
        for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
            if (!req_way_valids[i]) begin
                sel_way_c  = LOG_WAYS'(i);
                sel_free_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                plru_q[s] <= '0;
            end
            sweep_cnt_q    <= '0;
            busy_q         <= 1'b0;
            req_ready_q    <= 1'b1;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            victim_free_q  <= 1'b0;
        end else begin
            victim_valid_q <= req_fire_c;
            if (req_fire_c) begin
                victim_way_q  <= sel_way_c;
                victim_free_q <= sel_free_c;
            end
            if (upd_fire_c) begin
                plru_q[upd_index] <= upd_bits_c;
            end
            // Sweep clears one set per cycle; the wide counter makes the last set exact.
            if (busy_q) begin
                plru_q[sweep_cnt_q[LOG_SETS-1:0]] <= '0;
                if (sweep_cnt_q == CNT_W'(NUM_SETS - 1)) begin
                    sweep_cnt_q <= '0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end else begin
                    sweep_cnt_q <= sweep_cnt_q + CNT_W'(1);
                end
            end else if (flush_req) begin
                busy_q      <= 1'b1;
                req_ready_q <= 1'b0;
            end
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign victim_valid    = victim_valid_q;
    assign victim_way      = victim_way_q;
    assign victim_was_free = victim_free_q;

endmodule

// File: tb/tb_plru_replacement_unit.sv
// Self-checking bench for plru_replacement_unit: vector table, directed
// sequences and randomized traffic against a heap-arithmetic PLRU model.
module tb_plru_replacement_unit;

    localparam int NW = 4;
    localparam int LW = 2;
    localparam int NS = 16;
    localparam int LS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [LS-1:0] req_index;
    logic [NW-1:0] req_way_valids;
    logic          upd_valid;
    logic [LS-1:0] upd_index;
    logic [LW-1:0] upd_way;
    logic          flush_req;
    logic          busy;
    logic          victim_valid;
    logic [LW-1:0] victim_way;
    logic          victim_was_free;

    plru_replacement_unit #(.NUM_WAYS(NW), .LOG_WAYS(LW), .NUM_SETS(NS), .LOG_SETS(LS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_way_valids(req_way_valids),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way),
        .flush_req(flush_req), .busy(busy),
        .victim_valid(victim_valid), .victim_way(victim_way),
        .victim_was_free(victim_was_free)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: one bit per heap node (leaves unused), flush bookkeeping.
    bit m_bits [NS][2*NW-1];
    bit m_busy;
    int m_sweep;
    int m_vway;
    bit m_vfree;

    typedef struct {
        int            idx;
        logic [NW-1:0] vals;
        int            way;
        bit            free;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        foreach (m_bits[s, n]) m_bits[s][n] = 1'b0;
        m_busy  = 1'b0;
        m_sweep = 0;
        m_vway  = 0;
        m_vfree = 1'b0;
    endtask

    // Climb from the leaf; a lower child makes its parent point up (1), an upper child down (0).
    task automatic m_touch(input int set, input int way);
        int n, p;
        n = way + NW - 1;
        while (n > 0) begin
            p = (n - 1) / 2;
            m_bits[set][p] = (n == 2 * p + 1);
            n = p;
        end
    endtask

    function automatic int m_walk(input int set);
        int n;
        n = 0;
        while (n < NW - 1) n = 2 * n + 1 + int'(m_bits[set][n]);
        return n - (NW - 1);
    endfunction

    // One clock: drive inputs, advance the model, sample #1 after the edge and compare.
    task automatic cyc(input bit rv, input int ri, input logic [NW-1:0] rvals,
                       input bit uv, input int ui, input int uw, input bit fr);
        bit acc, exp_vv;
        req_valid      = rv;
        req_index      = LS'(ri);
        req_way_valids = rvals;
        upd_valid      = uv;
        upd_index      = LS'(ui);
        upd_way        = LW'(uw);
        flush_req      = fr;
        acc    = !m_busy;
        exp_vv = rv && acc;
        if (uv && acc) m_touch(ui, uw);
        if (exp_vv) begin
            m_vfree = 1'b0;
            for (int w = 0; w < NW; w++) begin
                if (!rvals[w] && !m_vfree) begin
                    m_vfree = 1'b1;
                    m_vway  = w;
                end
            end
            if (!m_vfree) m_vway = m_walk(ri);
        end
        if (m_busy) begin
            for (int n = 0; n < NW - 1; n++) m_bits[m_sweep][n] = 1'b0;
            m_sweep++;
            if (m_sweep == NS) begin
                m_busy  = 1'b0;
                m_sweep = 0;
            end
        end else if (fr) begin
            m_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("victim_valid", int'(victim_valid), int'(exp_vv));
        chk("victim_way", int'(victim_way), m_vway);
        chk("victim_was_free", int'(victim_was_free), int'(m_vfree));
        chk("busy", int'(busy), int'(m_busy));
        chk("req_ready", int'(req_ready), int'(!m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_index      = '0;
        req_way_valids = '1;
        upd_valid      = 1'b0;
        upd_index      = '0;
        upd_way        = '0;
        flush_req      = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst victim_valid", int'(victim_valid), 0);
        chk("rst victim_way", int'(victim_way), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst req_ready", int'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cycles;

        vecs[0] = '{idx: 3,  vals: 4'b1111, way: 0, free: 1'b0};
        vecs[1] = '{idx: 5,  vals: 4'b1011, way: 2, free: 1'b1};
        vecs[2] = '{idx: 5,  vals: 4'b0000, way: 0, free: 1'b1};
        vecs[3] = '{idx: 0,  vals: 4'b0111, way: 3, free: 1'b1};
        vecs[4] = '{idx: 15, vals: 4'b1101, way: 1, free: 1'b1};
        vecs[5] = '{idx: 9,  vals: 4'b1110, way: 0, free: 1'b1};

        do_reset();

        // Reset-state lookups from the vector table.
        foreach (vecs[i]) begin
            cyc(1, vecs[i].idx, vecs[i].vals, 0, 0, 0, 0);
            chk("vec way", int'(victim_way), vecs[i].way);
            chk("vec free", int'(victim_was_free), int'(vecs[i].free));
            cyc(0, 0, '1, 0, 0, 0, 0);
            chk("vec pulse", int'(victim_valid), 0);
        end

        // Index 2 update sequences.
        cyc(0, 0, '1, 1, 2, 0, 0);
        cyc(1, 2, '1, 0, 0, 0, 0);
        chk("seq upd0", int'(victim_way), 2);
        cyc(0, 0, '1, 1, 2, 2, 0);
        cyc(1, 2, '1, 0, 0, 0, 0);
        chk("seq upd2", int'(victim_way), 1);
        for (int w = 0; w < NW; w++) cyc(0, 0, '1, 1, 2, w, 0);
        cyc(1, 2, '1, 0, 0, 0, 0);
        chk("seq upd0123", int'(victim_way), 0);

        // Same-cycle forwarding versus independent index.
        do_reset();
        cyc(1, 7, '1, 1, 7, 0, 0);
        chk("fwd same", int'(victim_way), 2);
        cyc(1, 8, '1, 1, 7, 0, 0);
        chk("fwd diff", int'(victim_way), 0);

        // Flush: lookup and update in the pulse cycle, then requests while busy.
        for (int s = 0; s < NS; s += 3) cyc(0, 0, '1, 1, s, s % NW, 0);
        cyc(1, 3, '1, 1, 4, 1, 1);
        chk("flush-cycle lookup", int'(victim_valid), 1);
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            cyc(1, i % NS, '1, 1, i % NS, 3, 1);
        end
        chk("busy length", busy_cycles, NS);
        for (int s = 0; s < NS; s++) begin
            cyc(1, s, '1, 0, 0, 0, 0);
            chk("post-flush way", int'(victim_way), 0);
        end

        // Reset arriving mid-sweep with a lookup presented.
        for (int s = 0; s < NS; s++) cyc(0, 0, '1, 1, s, 0, 0);
        cyc(0, 0, '1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 6, '1, 0, 0, 0, 0);
        req_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("midrst victim_valid", int'(victim_valid), 0);
        chk("midrst victim_way", int'(victim_way), 0);
        chk("midrst free", int'(victim_was_free), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst req_ready", int'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        idle(2);
        for (int s = 0; s < NS; s++) begin
            cyc(1, s, '1, 0, 0, 0, 0);
            chk("midrst cleared", int'(victim_way), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [NW-1:0] v;
            v = ($urandom_range(0, 1) == 0) ? '1 : NW'($urandom);
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)), v,
                1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
                int'($urandom_range(0, NW - 1)), $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
